div_array_scheduler: RTL and testbench

- Sequencing and arbitration controller for the 16-by-8 triangular array divider core. Core ports: n[15:0], d[7:0], q[7:0], r[7:0]; exact or approximate variant.
- Shares one combinational core between two requesters (A, B) using round-robin arbitration.
- Registers the operands and holds them for a multicycle settle window, then captures the quotient and remainder.
- Returns each result on a valid/ready port, tagged with its source. Divide-by-zero and quotient overflow are detected up front and bypass the core.

---
 rtl/div_array_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_div_array_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_array_scheduler.sv
// div_array_scheduler: round-robin sequencer sharing one 16/8 array divider.
// Operands are held for a settle window, then the result is captured and returned.

module div_array_core (
    input  logic [15:0] n,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic [7:0]  r
);

    logic [8:0] rem [0:8];
    logic [8:0] d9;

    assign d9     = {1'b0, d};
    assign rem[0] = {1'b0, n[15:8]};

    // One restoring subtract row per quotient bit, MSB first.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_row
            logic [8:0] sh;
            logic       ge;
            assign sh         = {rem[i][7:0], n[7-i]};
            assign ge         = (sh >= d9);
            assign q[7-i]     = ge;
            assign rem[i+1]   = ge ? (sh - d9) : sh;
        end
    endgenerate

    assign r = rem[8][7:0];

endmodule

module div_array_scheduler #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_n,
    input  logic [7:0]  a_d,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_n,
    input  logic [7:0]  b_d,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_q,
    output logic [7:0]  res_r,
    output logic        res_src,
    output logic        res_dbz,
    output logic        res_ovf,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [15:0] op_n;
    logic [7:0]  op_d;
    logic        tag;
    logic        ptr;

    logic        sel_b;
    logic        grant_a;
    logic        grant_b;
    logic        idle;
    logic        accept;
    logic [15:0] in_n;
    logic [7:0]  in_d;
    logic        in_dbz;
    logic        in_ovf;
    logic        pop;
    logic [7:0]  core_q;
    logic [7:0]  core_r;

    // Grant selection: ptr = 1 means B wins a tie.
    assign sel_b   = b_valid & (~a_valid | ptr);
    assign grant_b = sel_b;
    assign grant_a = a_valid & ~sel_b;
    assign idle    = (state == IDLE);

    assign a_ready = idle & ~rst & grant_a;
    assign b_ready = idle & ~rst & grant_b;
    assign accept  = a_ready | b_ready;

    assign in_n    = sel_b ? b_n : a_n;
    assign in_d    = sel_b ? b_d : a_d;
    assign in_dbz  = (in_d == 8'd0);
    assign in_ovf  = (in_n[15:8] >= in_d);

    assign res_valid = (state == DONE);
    assign busy      = ~idle;
    assign pop       = res_valid & res_ready;

    // The core only ever sees the registered operands.
    div_array_core u_core (
        .n (op_n),
        .d (op_d),
        .q (core_q),
        .r (core_r)
    );

    // Control FSM and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_dbz || in_ovf) begin
                            state <= DONE;
                        end else begin
                            state <= SETTLE;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (pop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and source tag latch on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_n <= 16'd0;
            op_d <= 8'd0;
            tag  <= 1'b0;
        end else if (accept) begin
            op_n <= in_n;
            op_d <= in_d;
            tag  <= sel_b;
        end
    end

    // Round-robin pointer flips to the other requester on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~sel_b;
        end
    end

    // Result registers: exceptions load at accept, normal ops at settle end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= 8'd0;
            res_r   <= 8'd0;
            res_src <= 1'b0;
            res_dbz <= 1'b0;
            res_ovf <= 1'b0;
        end else if (accept && (in_dbz || in_ovf)) begin
            res_q   <= 8'hFF;
            res_r   <= 8'hFF;
            res_src <= sel_b;
            res_dbz <= in_dbz;
            res_ovf <= ~in_dbz;
        end else if (state == SETTLE && cnt == 8'd0) begin
            res_q   <= core_q;
            res_r   <= core_r;
            res_src <= tag;
            res_dbz <= 1'b0;
            res_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_array_scheduler.sv
// tb_div_array_scheduler: scoreboard bench for the shared divider sequencer.
// Covers arbitration, exceptions, backpressure, reset and a 1-cycle build.

module tb_div_array_scheduler;

    localparam int S = 4;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       src;
        logic       dbz;
        logic       ovf;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, res_ready;
    logic        a_ready, b_ready, res_valid;
    logic [15:0] a_n, b_n;
    logic [7:0]  a_d, b_d;
    logic [7:0]  res_q, res_r;
    logic        res_src, res_dbz, res_ovf, busy;

    logic        rst1;
    logic        a_valid1, b_valid1, res_ready1;
    logic        a_ready1, b_ready1, res_valid1;
    logic [15:0] a_n1, b_n1;
    logic [7:0]  a_d1, b_d1;
    logic [7:0]  res_q1, res_r1;
    logic        res_src1, res_dbz1, res_ovf1, busy1;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pops = 0;
    int   grants = 0;
    logic last_src = 1'b0;
    logic ptr_m = 1'b0;
    logic inflight = 1'b0;
    logic vseen = 1'b0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_array_scheduler #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_n(a_n), .a_d(a_d),
        .b_valid(b_valid), .b_ready(b_ready), .b_n(b_n), .b_d(b_d),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_r(res_r), .res_src(res_src),
        .res_dbz(res_dbz), .res_ovf(res_ovf), .busy(busy)
    );

    div_array_scheduler #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .a_valid(a_valid1), .a_ready(a_ready1), .a_n(a_n1), .a_d(a_d1),
        .b_valid(b_valid1), .b_ready(b_ready1), .b_n(b_n1), .b_d(b_d1),
        .res_valid(res_valid1), .res_ready(res_ready1),
        .res_q(res_q1), .res_r(res_r1), .res_src(res_src1),
        .res_dbz(res_dbz1), .res_ovf(res_ovf1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] n, input logic [7:0] d,
                                   input logic src, input int now);
        exp_t e;
        e.src = src;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (d == 8'd0) begin
            e.q = 8'hFF; e.r = 8'hFF; e.dbz = 1'b1; e.due = now + 1;
        end else if (n[15:8] >= d) begin
            e.q = 8'hFF; e.r = 8'hFF; e.ovf = 1'b1; e.due = now + 1;
        end else begin
            e.q = 8'(n / 16'(d));
            e.r = 8'(n % 16'(d));
            e.due = now + 1 + S;
        end
        return e;
    endfunction

    // Monitor: pushes expectations on handshake, pops on result transfer.
    always @(negedge clk) begin
        exp_t e;
        logic src;
        if (rst) begin
            sb.delete();
            inflight = 1'b0;
            vseen = 1'b0;
            ptr_m = 1'b0;
        end else begin
            if (inflight) chk("busy", 32'(busy), 1);
            chk("ready_excl", 32'(a_ready & b_ready), 0);
            if (res_valid && !vseen) begin
                vseen = 1'b1;
                if (sb.size() == 0) chk("unexpected_res", 1, 0);
                else chk("latency", cyc, sb[0].due);
            end
            if (res_valid && res_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_q", 32'(res_q), 32'(e.q));
                    chk("res_r", 32'(res_r), 32'(e.r));
                    chk("res_src", 32'(res_src), 32'(e.src));
                    chk("res_dbz", 32'(res_dbz), 32'(e.dbz));
                    chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
                end
                pops++;
                vseen = 1'b0;
                inflight = 1'b0;
            end
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                src = b_ready;
                if (a_valid && b_valid) chk("rr_grant", 32'(src), 32'(ptr_m));
                ptr_m = ~src;
                e = src ? model(b_n, b_d, 1'b1, cyc) : model(a_n, a_d, 1'b0, cyc);
                sb.push_back(e);
                inflight = 1'b1;
                last_src = src;
                grants++;
            end
        end
    end

    task automatic wait_pops(input int target);
        for (int k = 0; k < 400 && pops < target; k++) @(negedge clk);
        chk("wait_pops", 32'(pops >= target), 1);
    endtask

    task automatic wait_drain();
        @(negedge clk);
        for (int k = 0; k < 400 && (sb.size() != 0 || busy); k++)
            @(negedge clk);
        chk("drain", 32'(sb.size() == 0 && !busy), 1);
    endtask

    task automatic issue_a(input logic [15:0] n, input logic [7:0] d);
        int k;
        @(posedge clk); #1;
        a_n = n; a_d = d; a_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!a_ready && k < 100);
        chk("a_accept", 32'(a_ready), 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ardy"}, 32'(a_ready), 0);
        chk({tag, "_brdy"}, 32'(b_ready), 0);
        chk({tag, "_q"}, 32'(res_q), 0);
        chk({tag, "_r"}, 32'(res_r), 0);
        chk({tag, "_flags"}, 32'({res_src, res_dbz, res_ovf}), 0);
    endtask

    initial begin
        logic [7:0] sq, sr;
        logic [2:0] sf;
        int g0;

        rst = 1'b1; rst1 = 1'b1;
        res_ready = 1'b1; res_ready1 = 1'b1;
        a_valid = 1'b1; a_n = 16'd100; a_d = 8'd10;
        b_valid = 1'b1; b_n = 16'd255; b_d = 8'd16;
        a_valid1 = 1'b0; b_valid1 = 1'b0;
        a_n1 = '0; a_d1 = '0; b_n1 = '0; b_d1 = '0;
        #2;
        check_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; rst1 = 1'b0;

        // Both held: A, B, A, B.
        wait_pops(4);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_drain();

        issue_a(16'd1000, 8'd7);
        wait_drain();
        issue_a(16'h1234, 8'd0);
        wait_drain();
        issue_a(16'h0800, 8'd8);
        wait_drain();
        issue_a(16'h07FF, 8'd8);
        wait_drain();

        // Backpressure with both requesters pending.
        @(posedge clk); #1;
        res_ready = 1'b0;
        a_n = 16'd300; a_d = 8'd5; a_valid = 1'b1;
        b_n = 16'd500; b_d = 8'd9; b_valid = 1'b1;
        for (int k = 0; k < 100 && !res_valid; k++) @(negedge clk);
        chk("bp_valid", 32'(res_valid), 1);
        sq = res_q; sr = res_r; sf = {res_src, res_dbz, res_ovf};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(res_valid), 1);
            chk("bp_hold_q", 32'(res_q), 32'(sq));
            chk("bp_hold_r", 32'(res_r), 32'(sr));
            chk("bp_hold_flags", 32'({res_src, res_dbz, res_ovf}), 32'(sf));
            chk("bp_rdy", 32'({a_ready, b_ready}), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", 32'(busy), 0);
        chk("bp_regrant", 32'(a_ready | b_ready), 1);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_drain();

        // Reset during SETTLE discards the operation.
        issue_a(16'd1000, 8'd7);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #3;
        rst = 1'b0;
        g0 = grants;
        a_n = 16'd50; a_d = 8'd3; a_valid = 1'b1;
        b_n = 16'd60; b_d = 8'd7; b_valid = 1'b1;
        for (int k = 0; k < 100 && grants == g0; k++) @(negedge clk);
        chk("post_rst_grant", 32'(grants > g0), 1);
        chk("post_rst_src", 32'(last_src), 0);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_drain();

        // SETTLE_CYCLES = 1 build.
        @(posedge clk); #1;
        a_n1 = 16'hFFFF; a_d1 = 8'hFF; a_valid1 = 1'b1;
        @(negedge clk);
        chk("s1_acc0", 32'(a_ready1), 1);
        @(posedge clk); #1;
        a_valid1 = 1'b0;
        @(negedge clk);
        chk("s1_ovf_valid", 32'(res_valid1), 1);
        chk("s1_ovf", 32'({res_dbz1, res_ovf1}), 32'(2'b01));
        chk("s1_ovf_qr", 32'({res_q1, res_r1}), 32'(16'hFFFF));
        @(posedge clk); #1;
        a_n1 = 16'hFEFF; a_d1 = 8'hFF; a_valid1 = 1'b1;
        @(negedge clk);
        chk("s1_acc1", 32'(a_ready1), 1);
        @(posedge clk); #1;
        a_valid1 = 1'b0;
        @(negedge clk);
        chk("s1_settle", 32'(res_valid1), 0);
        @(negedge clk);
        chk("s1_valid", 32'(res_valid1), 1);
        chk("s1_q", 32'(res_q1), 32'hFF);
        chk("s1_r", 32'(res_r1), 32'hFE);
        chk("s1_flags", 32'({res_src1, res_dbz1, res_ovf1}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        chk("global_timeout", 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
